sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Parametrised synchronous controller between a valid/ready request bus and one asynchronous SRAM bank (Sram_if pin style: address, tri-state data, ce_n/oe_n/we_n/be_n).
- Generalises the fixed 32-bit, 1 MiB-word bank pairing to configurable data width, address width, byte-lane count and read/write wait states.
- Adds a read-to-write bus turnaround and single-outstanding response signalling.
- Sits between the CPU/bus fabric and each of base_ram/ext_ram, one instance per bank.

Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 8.
- ADDR_WIDTH, 20, word address width.
- READ_WAIT, 2, cycles oe_n held low per read; legal values >=1.
- WRITE_WAIT, 2, cycles we_n held low per write; legal values >=1.
- TURNAROUND, 1, idle cycles inserted after every read before the next access; legal values >=0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request this cycle
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  word address
- req_be  in  DATA_WIDTH/8  active-high byte enables (writes only)
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  read data; valid only with resp_valid after a read
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_dq_o  out  DATA_WIDTH  data driven to pins
- sram_dq_oe  out  1  1=drive pins
- sram_dq_i  in  DATA_WIDTH  data sampled from pins
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_be_n  out  DATA_WIDTH/8  byte enables, active low
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - ce_n/oe_n/we_n=1; be_n all ones; dq_oe=0.
  - sram_addr=0, dq_o=0, resp_valid=0, resp_rdata=0, busy=0; state=IDLE.
- Reset mid-operation: pins return to reset values immediately; the in-flight transaction is dropped and no resp_valid is issued.
- req_ready = (state==IDLE). Handshake fires on req_valid&req_ready in cycle T.
- At the handshake, latch addr/we/be/wdata; request inputs are ignored while busy.
- All SRAM outputs are registered.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN.
- Read:
  - IDLE->RD at T. RD occupies T+1..T+READ_WAIT with ce_n=0, oe_n=0, be_n=0 (full word), dq_oe=0.
  - sram_dq_i is sampled at the clock edge ending the last RD cycle.
  - resp_valid=1 and resp_rdata=sampled data in cycle T+READ_WAIT+1.
  - That cycle is TURN if TURNAROUND>0 (all strobes high, dq_oe=0, lasting TURNAROUND cycles), else IDLE.
  - Back-to-back reads: one accept every READ_WAIT+TURNAROUND+1 cycles.
- Write:
  - WR_SETUP at T+1: ce_n=0, we_n=1, addr/dq_o/be_n=~be valid, dq_oe=1.
  - WR_PULSE at T+2..T+1+WRITE_WAIT: we_n=0.
  - WR_HOLD for 1 cycle: we_n=1, ce_n=0, dq still driven; resp_valid=1, resp_rdata unchanged.
  - Then IDLE, with dq_oe=0 from that cycle.
  - Write occupancy is WRITE_WAIT+2 cycles.
- req_be==0 on a write: full cycle still executed with be_n all ones; response still issued.
- we_n and oe_n are never low in the same cycle.
- dq_oe=1 only in the WR_* states.
- sram_addr holds its last value in IDLE/TURN.
- Wait counter width is $clog2(max(READ_WAIT,WRITE_WAIT,TURNAROUND)+1).
- resp_valid is never asserted in consecutive cycles.

Test Plan:
- Write + readback (defaults): write addr 0x00123, be=4'hF, wdata 0xDEADBEEF.
  - Expect we_n low for exactly 2 cycles and resp_valid at T+4.
  - Read addr 0x00123: resp_valid at T+3 with rdata 0xDEADBEEF; req_ready low for 1 TURN cycle after.
- Partial write: preload 0x11223344, write be=4'b0101 wdata 0xAABBCCDD.
  - Expect be_n=4'b1010 during the pulse; readback 0x11BB33DD.
- Read->write turnaround: read then immediately write, with req_valid held high.
  - Expect dq_oe rising no earlier than 1 cycle after oe_n rises.
  - Expect no cycle with oe_n=0 and dq_oe=1.
- Back-to-back reads: 4 reads to addrs 0..3 with req_valid always high.
  - Expect accepts spaced 4 cycles apart and 4 resp_valid pulses with the correct data.
- Reset mid-write: assert rst_n=0 during WR_PULSE.
  - Expect we_n=1, ce_n=1 and dq_oe=0 asynchronously, no resp_valid, req_ready=1 one cycle after release.
- Variant DATA_WIDTH=16, READ_WAIT=1, TURNAROUND=0: reads spaced 2 cycles apart, be_n 2 bits wide; write/read of 0xA55A round-trips.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: valid/ready request bus to one asynchronous SRAM bank.
// Registered pin outputs, read-to-write turnaround, one request in flight.
module sram_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter int TURNAROUND = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_dq_o,
  output logic                    sram_dq_oe,
  input  logic [DATA_WIDTH-1:0]   sram_dq_i,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [DATA_WIDTH/8-1:0] sram_be_n,
  output logic                    busy
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int MRW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int MAXW = (MRW > TURNAROUND) ? MRW : TURNAROUND;
  localparam int CW = $clog2(MAXW + 1);
  localparam int TAL = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_WAIT - 1);
  localparam logic [CW-1:0] TA_LOAD = CW'(TAL);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    TURN
  } state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] dq_o_d, rdata_d;
  logic [BW-1:0]         be_n_d;
  logic                  dq_oe_d, ce_n_d, oe_n_d, we_n_d;
  logic                  resp_valid_d;
  logic                  accept;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // State, wait counter and every pin / response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sram_addr  <= addr_d;
      sram_dq_o  <= dq_o_d;
      sram_dq_oe <= dq_oe_d;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_be_n  <= be_n_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= rdata_d;
    end
  end

  // Next state and next pin values; strobes idle high unless a state claims them.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    addr_d       = sram_addr;
    dq_o_d       = sram_dq_o;
    rdata_d      = resp_rdata;
    be_n_d       = '1;
    dq_oe_d      = 1'b0;
    ce_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    resp_valid_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          ce_n_d = 1'b0;
          if (req_we) begin
            state_d = WR_SETUP;
            dq_oe_d = 1'b1;
            dq_o_d  = req_wdata;
            be_n_d  = ~req_be;
          end else begin
            state_d = RD;
            oe_n_d  = 1'b0;
            be_n_d  = '0;
            cnt_d   = RD_LOAD;
          end
        end
      end
      RD: begin
        if (cnt == '0) begin
          rdata_d      = sram_dq_i;
          resp_valid_d = 1'b1;
          if (TURNAROUND > 0) begin
            state_d = TURN;
            cnt_d   = TA_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d  = cnt - 1'b1;
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
          be_n_d = '0;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WR_LOAD;
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        be_n_d  = sram_be_n;
      end
      WR_PULSE: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        be_n_d  = sram_be_n;
        if (cnt == '0) begin
          state_d      = WR_HOLD;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d  = cnt - 1'b1;
          we_n_d = 1'b0;
        end
      end
      WR_HOLD: begin
        state_d = IDLE;
      end
      TURN: begin
        if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: randomized bench with a behavioural SRAM and a
// word-level reference memory for the default and a 16-bit variant.
module tb_sram_controller;

  localparam int DW = 32;
  localparam int AW = 20;
  localparam int RW = 2;
  localparam int WW = 2;
  localparam int TA = 1;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          a_req_valid = 1'b0;
  logic          a_req_we = 1'b0;
  logic [AW-1:0] a_req_addr = '0;
  logic [BW-1:0] a_req_be = '0;
  logic [DW-1:0] a_req_wdata = '0;
  logic          a_req_ready, a_resp_valid, a_dq_oe;
  logic          a_ce_n, a_oe_n, a_we_n, a_busy;
  logic [DW-1:0] a_resp_rdata, a_dq_o, a_dq_i;
  logic [AW-1:0] a_addr;
  logic [BW-1:0] a_be_n;

  logic          b_req_valid = 1'b0;
  logic          b_req_we = 1'b0;
  logic [AW-1:0] b_req_addr = '0;
  logic [1:0]    b_req_be = '0;
  logic [15:0]   b_req_wdata = '0;
  logic          b_req_ready, b_resp_valid, b_dq_oe;
  logic          b_ce_n, b_oe_n, b_we_n, b_busy;
  logic [15:0]   b_resp_rdata, b_dq_o, b_dq_i;
  logic [AW-1:0] b_addr;
  logic [1:0]    b_be_n;

  sram_controller dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr),
    .req_be(a_req_be), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .sram_addr(a_addr), .sram_dq_o(a_dq_o),
    .sram_dq_oe(a_dq_oe), .sram_dq_i(a_dq_i),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n),
    .sram_we_n(a_we_n), .sram_be_n(a_be_n),
    .busy(a_busy)
  );

  sram_controller #(
    .DATA_WIDTH(16), .ADDR_WIDTH(AW),
    .READ_WAIT(1), .WRITE_WAIT(2), .TURNAROUND(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr),
    .req_be(b_req_be), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .sram_addr(b_addr), .sram_dq_o(b_dq_o),
    .sram_dq_oe(b_dq_oe), .sram_dq_i(b_dq_i),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
    .sram_we_n(b_we_n), .sram_be_n(b_be_n),
    .busy(b_busy)
  );

  // Behavioural asynchronous SRAMs on the pins.
  logic [DW-1:0] mem_a [2**AW];
  logic [15:0]   mem_b [2**AW];
  assign a_dq_i = (!a_ce_n && !a_oe_n) ? mem_a[a_addr] : '0;
  assign b_dq_i = (!b_ce_n && !b_oe_n) ? mem_b[b_addr] : '0;

  always @(posedge clk) begin
    if (!a_ce_n && !a_we_n && a_dq_oe)
      for (int i = 0; i < BW; i++)
        if (!a_be_n[i]) mem_a[a_addr][i*8 +: 8] <= a_dq_o[i*8 +: 8];
    if (!b_ce_n && !b_we_n && b_dq_oe)
      for (int i = 0; i < 2; i++)
        if (!b_be_n[i]) mem_b[b_addr][i*8 +: 8] <= b_dq_o[i*8 +: 8];
  end

  // Reference model: word memory plus expected response queue.
  logic [DW-1:0] ref_a [2**AW];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] exp_d_a [$];
  int            exp_l_a [$];

  // Observed events.
  int            acc_a [$];
  int            rsp_a [$];
  logic [DW-1:0] rdat_a [$];
  int            wel_a [$];
  logic [BW-1:0] ben_a [$];
  int            we_run_a = 0;
  int            viol_a = 0;
  logic          p_oe_a = 1'b1;
  logic          p_rv_a = 1'b0;
  int            acc_b [$];
  int            rsp_b [$];
  logic [15:0]   rdat_b [$];

  // Pin monitor for instance A, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      p_oe_a   <= 1'b1;
      p_rv_a   <= 1'b0;
      we_run_a <= 0;
    end else begin
      if (a_req_valid && a_req_ready) acc_a.push_back(cyc);
      if (a_resp_valid) begin
        rsp_a.push_back(cyc);
        rdat_a.push_back(a_resp_rdata);
      end
      if (!a_we_n && we_run_a == 0) ben_a.push_back(a_be_n);
      if (!a_we_n) we_run_a <= we_run_a + 1;
      else if (we_run_a != 0) begin
        wel_a.push_back(we_run_a);
        we_run_a <= 0;
      end
      viol_a <= viol_a
        + int'(!a_oe_n && !a_we_n)
        + int'(a_dq_oe && (!a_oe_n || !p_oe_a))
        + int'(a_dq_oe && a_ce_n)
        + int'(a_resp_valid && p_rv_a);
      p_oe_a <= a_oe_n;
      p_rv_a <= a_resp_valid;
    end
  end

  // Event monitor for instance B.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_req_valid && b_req_ready) acc_b.push_back(cyc);
      if (b_resp_valid) begin
        rsp_b.push_back(cyc);
        rdat_b.push_back(b_resp_rdata);
      end
    end
  end

  task automatic clear_a();
    acc_a.delete();
    rsp_a.delete();
    rdat_a.delete();
    wel_a.delete();
    ben_a.delete();
    exp_d_a.delete();
    exp_l_a.delete();
  endtask

  task automatic clear_b();
    acc_b.delete();
    rsp_b.delete();
    rdat_b.delete();
  endtask

  // Present a request on A, wait for its handshake, update the model.
  task automatic issue_a(input logic we, input logic [AW-1:0] ad,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
    int n = 0;
    a_req_valid = 1'b1;
    a_req_we = we;
    a_req_addr = ad;
    a_req_be = be;
    a_req_wdata = wd;
    @(negedge clk);
    while (!a_req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (!a_req_ready) begin
      n_bad++;
      $display("FAIL accept_a: req_ready=%b after %0d cycles, required 1",
               a_req_ready, n);
    end else if (we) begin
      for (int i = 0; i < BW; i++)
        if (be[i]) ref_a[ad][i*8 +: 8] = wd[i*8 +: 8];
      exp_d_a.push_back(last_a);
      exp_l_a.push_back(WW + 2);
    end else begin
      last_a = ref_a[ad];
      exp_d_a.push_back(last_a);
      exp_l_a.push_back(RW + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_b(input logic we, input logic [AW-1:0] ad,
                         input logic [1:0] be, input logic [15:0] wd);
    int n = 0;
    b_req_valid = 1'b1;
    b_req_we = we;
    b_req_addr = ad;
    b_req_be = be;
    b_req_wdata = wd;
    @(negedge clk);
    while (!b_req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (!b_req_ready) begin
      n_bad++;
      $display("FAIL accept_b: req_ready=%b after %0d cycles, required 1",
               b_req_ready, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_a(input int want);
    int k = 0;
    while (rsp_a.size() < want && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (rsp_a.size() < want) begin
      n_bad++;
      $display("FAIL resp_count_a: got %0d responses, required %0d",
               rsp_a.size(), want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_b(input int want);
    int k = 0;
    while (rsp_b.size() < want && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (rsp_b.size() < want) begin
      n_bad++;
      $display("FAIL resp_count_b: got %0d responses, required %0d",
               rsp_b.size(), want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_ce_n, a_oe_n, a_we_n, a_dq_oe, a_resp_valid, a_busy} !== 6'b111000) begin
      n_bad++;
      $display("FAIL reset_strobes: ce/oe/we/dq_oe/rv/busy=%b, required 111000",
               {a_ce_n, a_oe_n, a_we_n, a_dq_oe, a_resp_valid, a_busy});
    end
    n_cmp++;
    if (a_be_n !== 4'hF) begin
      n_bad++;
      $display("FAIL reset_be_n: got %b, required 1111", a_be_n);
    end
    n_cmp++;
    if ({a_addr, a_dq_o, a_resp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: addr=%h dq_o=%h rdata=%h, required 0",
               a_addr, a_dq_o, a_resp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (a_req_ready !== 1'b1 || a_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: ready=%b busy=%b, required 1/0",
               a_req_ready, a_busy);
    end
    n_cmp++;
    if ({b_ce_n, b_oe_n, b_we_n, b_dq_oe, b_be_n} !== 6'b111011) begin
      n_bad++;
      $display("FAIL reset_b: pins=%b, required 111011",
               {b_ce_n, b_oe_n, b_we_n, b_dq_oe, b_be_n});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_readback();
    clear_a();
    issue_a(1'b1, 20'h00123, 4'hF, 32'hDEADBEEF);
    a_req_valid = 1'b0;
    wait_rsp_a(1);
    n_cmp++;
    if (wel_a.size() != 1 || wel_a[0] != WW) begin
      n_bad++;
      $display("FAIL we_pulse: pulses=%0d width=%0d, required 1 of %0d",
               wel_a.size(), (wel_a.size() > 0) ? wel_a[0] : 0, WW);
    end
    n_cmp++;
    if (rsp_a[0] - acc_a[0] != 4) begin
      n_bad++;
      $display("FAIL write_latency: got %0d, required 4", rsp_a[0] - acc_a[0]);
    end
    issue_a(1'b0, 20'h00123, '0, '0);
    a_req_valid = 1'b0;
    for (int k = 1; k <= RW + TA + 1; k++) begin
      @(negedge clk);
      n_cmp++;
      if (a_req_ready !== (k == RW + TA + 1)) begin
        n_bad++;
        $display("FAIL read_ready_c%0d: got %b, required %b",
                 k, a_req_ready, k == RW + TA + 1);
      end
    end
    @(posedge clk);
    #1;
    wait_rsp_a(2);
    n_cmp++;
    if (rdat_a[1] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL readback: got %h, required deadbeef", rdat_a[1]);
    end
    n_cmp++;
    if (rsp_a[1] - acc_a[1] != 3) begin
      n_bad++;
      $display("FAIL read_latency: got %0d, required 3", rsp_a[1] - acc_a[1]);
    end
  endtask

  task automatic test_partial_write();
    clear_a();
    issue_a(1'b1, 20'h00040, 4'hF, 32'h11223344);
    issue_a(1'b1, 20'h00040, 4'b0101, 32'hAABBCCDD);
    a_req_valid = 1'b0;
    issue_a(1'b0, 20'h00040, '0, '0);
    a_req_valid = 1'b0;
    wait_rsp_a(3);
    n_cmp++;
    if (ben_a[1] !== 4'b1010) begin
      n_bad++;
      $display("FAIL partial_be_n: got %b, required 1010", ben_a[1]);
    end
    n_cmp++;
    if (rdat_a[2] !== 32'h11BB33DD || rdat_a[2] !== exp_d_a[2]) begin
      n_bad++;
      $display("FAIL partial_data: got %h, required 11bb33dd (model %h)",
               rdat_a[2], exp_d_a[2]);
    end
  endtask

  task automatic test_turnaround();
    clear_a();
    issue_a(1'b0, 20'h00123, '0, '0);
    issue_a(1'b1, 20'h00124, 4'hF, $urandom);
    a_req_valid = 1'b0;
    issue_a(1'b0, 20'h00124, '0, '0);
    a_req_valid = 1'b0;
    wait_rsp_a(3);
    n_cmp++;
    if (acc_a[1] - acc_a[0] != RW + TA + 1) begin
      n_bad++;
      $display("FAIL rd_wr_spacing: got %0d, required %0d",
               acc_a[1] - acc_a[0], RW + TA + 1);
    end
    n_cmp++;
    if (rdat_a[2] !== exp_d_a[2]) begin
      n_bad++;
      $display("FAIL turn_data: got %h, required %h", rdat_a[2], exp_d_a[2]);
    end
    n_cmp++;
    if (viol_a != 0) begin
      n_bad++;
      $display("FAIL turn_bus: %0d bus conflicts, required 0", viol_a);
    end
  endtask

  task automatic test_back_to_back();
    clear_a();
    for (int i = 0; i < 4; i++) issue_a(1'b1, AW'(i), 4'hF, $urandom);
    for (int i = 0; i < 4; i++) issue_a(1'b0, AW'(i), '0, '0);
    a_req_valid = 1'b0;
    wait_rsp_a(8);
    for (int i = 5; i < 8; i++) begin
      n_cmp++;
      if (acc_a[i] - acc_a[i-1] != RW + TA + 1) begin
        n_bad++;
        $display("FAIL b2b_spacing%0d: got %0d, required %0d",
                 i, acc_a[i] - acc_a[i-1], RW + TA + 1);
      end
    end
    for (int i = 4; i < 8; i++) begin
      n_cmp++;
      if (rdat_a[i] !== exp_d_a[i]) begin
        n_bad++;
        $display("FAIL b2b_data%0d: got %h, required %h",
                 i, rdat_a[i], exp_d_a[i]);
      end
    end
  endtask

  task automatic test_random();
    logic          we;
    logic [AW-1:0] ad;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    clear_a();
    for (int i = 0; i < 16; i++) issue_a(1'b1, AW'(i), 4'hF, $urandom);
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      ad = AW'($urandom_range(0, 15));
      be = BW'($urandom);
      wd = $urandom;
      issue_a(we, ad, be, wd);
      if ($urandom_range(0, 2) == 0) begin
        a_req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    a_req_valid = 1'b0;
    wait_rsp_a(56);
    n_cmp++;
    if (rsp_a.size() != exp_d_a.size()) begin
      n_bad++;
      $display("FAIL rand_count: got %0d, required %0d",
               rsp_a.size(), exp_d_a.size());
    end
    for (int i = 0; i < rsp_a.size() && i < exp_d_a.size(); i++) begin
      n_cmp += 2;
      if (rdat_a[i] !== exp_d_a[i]) begin
        n_bad++;
        $display("FAIL rand_data%0d: got %h, required %h",
                 i, rdat_a[i], exp_d_a[i]);
      end
      if (rsp_a[i] - acc_a[i] != exp_l_a[i]) begin
        n_bad++;
        $display("FAIL rand_latency%0d: got %0d, required %0d",
                 i, rsp_a[i] - acc_a[i], exp_l_a[i]);
      end
    end
  endtask

  task automatic test_variant();
    clear_b();
    issue_b(1'b1, 20'h00005, 2'b11, 16'hA55A);
    b_req_valid = 1'b0;
    wait_rsp_b(1);
    issue_b(1'b0, 20'h00005, 2'b00, 16'h0000);
    b_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({b_oe_n, b_be_n, b_busy} !== 4'b0001) begin
      n_bad++;
      $display("FAIL var_read_pins: oe_n/be_n/busy=%b, required 0001",
               {b_oe_n, b_be_n, b_busy});
    end
    @(posedge clk);
    #1;
    wait_rsp_b(2);
    n_cmp++;
    if (rdat_b[1] !== 16'hA55A) begin
      n_bad++;
      $display("FAIL var_data: got %h, required a55a", rdat_b[1]);
    end
    n_cmp++;
    if (rsp_b[0] - acc_b[0] != 4 || rsp_b[1] - acc_b[1] != 2) begin
      n_bad++;
      $display("FAIL var_latency: wr %0d rd %0d, required 4 and 2",
               rsp_b[0] - acc_b[0], rsp_b[1] - acc_b[1]);
    end
    for (int i = 0; i < 3; i++) issue_b(1'b0, 20'h00005, 2'b00, 16'h0000);
    b_req_valid = 1'b0;
    wait_rsp_b(5);
    for (int i = 3; i < 5; i++) begin
      n_cmp++;
      if (acc_b[i] - acc_b[i-1] != 2 || rdat_b[i] !== 16'hA55A) begin
        n_bad++;
        $display("FAIL var_b2b%0d: spacing %0d data %h, required 2 and a55a",
                 i, acc_b[i] - acc_b[i-1], rdat_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    clear_a();
    issue_a(1'b1, 20'h00200, 4'hF, 32'h0BADF00D);
    a_req_valid = 1'b0;
    @(negedge clk);
    while (a_we_n && n < 10) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (a_we_n !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_pulse: we_n=%b, required 0", a_we_n);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_we_n, a_ce_n, a_dq_oe} !== 3'b110) begin
      n_bad++;
      $display("FAIL async_reset: we_n/ce_n/dq_oe=%b, required 110",
               {a_we_n, a_ce_n, a_dq_oe});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_a = '0;
    clear_a();
    @(negedge clk);
    n_cmp++;
    if (a_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_ready: got %b, required 1", a_req_ready);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (rsp_a.size() != 0) begin
      n_bad++;
      $display("FAIL dropped_resp: got %0d responses, required 0",
               rsp_a.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (viol_a != 0) begin
      n_bad++;
      $display("FAIL protocol: %0d strobe/bus conflicts, required 0", viol_a);
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_partial_write();
    test_turnaround();
    test_back_to_back();
    test_random();
    test_variant();
    test_reset_mid_write();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
